// File: rtl/jtopl_pkg.sv
// jtopl_pkg: constants and small helpers shared by the OPL rhythm noise logic.
//   LFSR_W     noise register width
//   LFSR_SEED  value the noise register restarts from
//   FB_TAP     second feedback tap (the first tap is bit 0)
//   req_idx_e  requester positions in the req/gnt vectors
//   rr_next    round-robin successor of a requester index
package jtopl_pkg;

  localparam int          LFSR_W    = 23;
  localparam logic [22:0] LFSR_SEED = 23'h400000;
  localparam int          FB_TAP    = 14;
  localparam int          NREQ      = 3;

  typedef enum logic [1:0] {
    REQ_HH = 2'd0,
    REQ_SD = 2'd1,
    REQ_TC = 2'd2
  } req_idx_e;

  // Successor of a requester index, wrapping after the top-cymbal slot.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'(REQ_TC)) ? 2'(REQ_HH) : idx + 2'd1;
  endfunction

endpackage

// File: rtl/jtopl_noise_lfsr.sv
// jtopl_noise_lfsr: 23-bit rhythm noise shift register.
// Optional feature macro: JTOPL_NOISE_LOAD_EN (enables the seed load path).
// Ports:
//   clk_i    system clock
//   rst_i    synchronous active-high reset
//   step_i   advance the register by one position
//   load_i   load seed_i (only with JTOPL_NOISE_LOAD_EN, wins over step_i)
//   seed_i   value to load
//   lfsr_o   current register contents
//   step0_o  bit 0 the register holds after a step from its current value
module jtopl_noise_lfsr
  import jtopl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              step_i,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] seed_i,
  output logic [LFSR_W-1:0] lfsr_o,
  output logic              step0_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  logic [LFSR_W-1:0] stepped;
  logic              fb;

  // A cleared register would shift zeros forever, so feedback is forced high
  // to pull it back to the seed value on the next step.
  always_comb begin
    fb = lfsr_q[0] ^ lfsr_q[FB_TAP];
    if (lfsr_q == '0) fb = 1'b1;
    stepped = {fb, lfsr_q[LFSR_W-1:1]};
    lfsr_d  = lfsr_q;
    if (step_i) lfsr_d = stepped;
`ifdef JTOPL_NOISE_LOAD_EN
    if (load_i) lfsr_d = seed_i;
`endif
  end

`ifndef JTOPL_NOISE_LOAD_EN
  logic unused_load;
  assign unused_load = ^{load_i, seed_i};
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign lfsr_o  = lfsr_q;
  assign step0_o = stepped[0];

endmodule

// File: rtl/jtopl_noise_ctl.sv
// jtopl_noise_ctl: per-sample slot counter, noise LFSR scheduling, noise-bit
// snapshot and round-robin sharing of that bit among HH, SD and TC.
// Optional feature macro: JTOPL_NOISE_LOAD_EN (seed load into the LFSR).
// Ports:
//   clk_i     system clock
//   rst_i     synchronous active-high reset (overrides cen_i)
//   cen_i     clock enable for all state
//   rhy_en_i  rhythm mode; no grants while low
//   req_i     requests, bit0 HH, bit1 SD, bit2 TC
//   load_i    seed load strobe (feature macro only)
//   seed_i    seed value (feature macro only)
//   gnt_o     one-hot grant, one cen cycle wide
//   nbit_o    noise bit handed out with the grant
//   slot_o    slot index within the sample
//   smp_o     high while slot_o is 0
module jtopl_noise_ctl
  import jtopl_pkg::*;
#(
  parameter int SLOTS = 18
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cen_i,
  input  logic              rhy_en_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] seed_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic              nbit_o,
  output logic [4:0]        slot_o,
  output logic              smp_o
);

  localparam logic [4:0] SLOT_LAST = 5'(SLOTS - 1);

  logic [4:0]        slot_q;
  logic              smp_q;
  logic              snap_q;
  logic [NREQ-1:0]   srv_q;
  logic [1:0]        ptr_q;
  logic [NREQ-1:0]   gnt_q;
  logic              nbit_q;

  logic              boundary;
  logic [LFSR_W-1:0] lfsr_w;
  logic              step0_w;
  logic              snap_d;
  logic [NREQ-1:0]   srv_eff;
  logic [NREQ-1:0]   elig;
  logic              grant_vld;
  logic [1:0]        grant_idx;
  logic [1:0]        idx;
  logic [NREQ-1:0]   grant_oh;

  assign boundary = cen_i && (slot_q == SLOT_LAST);

  jtopl_noise_lfsr u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .step_i  (boundary),
    .load_i  (cen_i & load_i),
    .seed_i  (seed_i),
    .lfsr_o  (lfsr_w),
    .step0_o (step0_w)
  );

  // On the wrap cycle the served mask is cleared before arbitration and the
  // new snapshot is taken from the LFSR's post-step bit, so a grant landing
  // on that cycle already belongs to the new sample.
  always_comb begin
    snap_d    = boundary ? step0_w : snap_q;
    srv_eff   = boundary ? '0 : srv_q;
    elig      = req_i & ~srv_eff;
    grant_vld = 1'b0;
    grant_idx = ptr_q;
    idx       = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_vld && elig[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
      idx = rr_next(idx);
    end
    grant_vld = grant_vld & rhy_en_i;
    grant_oh  = 3'b001 << grant_idx;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q <= '0;
      smp_q  <= 1'b1;
      snap_q <= 1'b0;
      srv_q  <= '0;
      ptr_q  <= 2'(REQ_HH);
      gnt_q  <= '0;
      nbit_q <= 1'b0;
    end else if (cen_i) begin
      slot_q <= boundary ? '0 : slot_q + 5'd1;
      smp_q  <= boundary;
      snap_q <= snap_d;
      if (grant_vld) begin
        gnt_q  <= grant_oh;
        nbit_q <= snap_d;
        ptr_q  <= rr_next(grant_idx);
        srv_q  <= srv_eff | grant_oh;
      end else begin
        gnt_q  <= '0;
        srv_q  <= srv_eff;
      end
    end
  end

  assign gnt_o  = gnt_q;
  assign nbit_o = nbit_q;
  assign slot_o = slot_q;
  assign smp_o  = smp_q;

endmodule

// File: tb/tb_jtopl_noise_ctl.sv
// tb_jtopl_noise_ctl: directed and randomized checks of jtopl_noise_ctl
// against a behavioural model of the noise scheduler.
module tb_jtopl_noise_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic        rhyEn;
  logic [2:0]  req;
  logic        load;
  logic [22:0] seed;
  logic [2:0]  gnt;
  logic        nbit;
  logic [4:0]  slot;
  logic        smp;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int          mSlot;
  bit          mSmp;
  logic [22:0] mLfsr;
  bit          mSnap;
  bit          mServed[3];
  int          mPtr;
  logic [2:0]  mGnt;
  bit          mNbit;

  jtopl_noise_ctl #(.SLOTS(18)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .cen_i    (cen),
    .rhy_en_i (rhyEn),
    .req_i    (req),
    .load_i   (load),
    .seed_i   (seed),
    .gnt_o    (gnt),
    .nbit_o   (nbit),
    .slot_o   (slot),
    .smp_o    (smp)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // One noise step: right shift, new top bit from bits 0 and 14, zero recovers.
  function automatic logic [22:0] noiseStep(input logic [22:0] v);
    int fb;
    fb = int'(v[0]) ^ int'(v[14]);
    if (v == 23'd0) fb = 1;
    return (v >> 1) | (23'(fb) << 22);
  endfunction

  task automatic modelReset();
    mSlot = 0;
    mSmp  = 1'b1;
    mLfsr = 23'h400000;
    mSnap = 1'b0;
    for (int i = 0; i < 3; i++) mServed[i] = 1'b0;
    mPtr  = 0;
    mGnt  = 3'b000;
    mNbit = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic modelClock();
    bit          bnd;
    int          found;
    logic [22:0] nextL;
    if (rst) begin
      modelReset();
    end else if (cen) begin
      bnd   = (mSlot == 17);
      mSlot = bnd ? 0 : mSlot + 1;
      mSmp  = (mSlot == 0);
      nextL = mLfsr;
      if (bnd) begin
        nextL = noiseStep(mLfsr);
        mSnap = nextL[0];
        for (int i = 0; i < 3; i++) mServed[i] = 1'b0;
      end
`ifdef JTOPL_NOISE_LOAD_EN
      if (load) nextL = seed;
`endif
      mLfsr = nextL;
      found = -1;
      for (int k = 0; k < 3; k++) begin
        int c;
        c = (mPtr + k) % 3;
        if (found < 0 && req[c] && !mServed[c]) found = c;
      end
      if (rhyEn && found >= 0) begin
        mGnt = 3'b001 << found;
        mServed[found] = 1'b1;
        mPtr  = (found + 1) % 3;
        mNbit = mSnap;
      end else begin
        mGnt = 3'b000;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    assert (gnt === mGnt) else begin
      failures++;
      $error("FAIL %s gnt got=%b exp=%b", tag, gnt, mGnt);
    end
    checks++;
    assert (nbit === mNbit) else begin
      failures++;
      $error("FAIL %s nbit got=%b exp=%b", tag, nbit, mNbit);
    end
    checks++;
    assert (slot === 5'(mSlot)) else begin
      failures++;
      $error("FAIL %s slot got=%0d exp=%0d", tag, slot, mSlot);
    end
    checks++;
    assert (smp === mSmp) else begin
      failures++;
      $error("FAIL %s smp got=%b exp=%b", tag, smp, mSmp);
    end
    checks++;
    assert (dut.lfsr_w === mLfsr) else begin
      failures++;
      $error("FAIL %s lfsr got=%h exp=%h", tag, dut.lfsr_w, mLfsr);
    end
    checks++;
    assert (dut.snap_q === mSnap) else begin
      failures++;
      $error("FAIL %s snap got=%b exp=%b", tag, dut.snap_q, mSnap);
    end
    checks++;
    assert (dut.ptr_q === 2'(mPtr)) else begin
      failures++;
      $error("FAIL %s ptr got=%0d exp=%0d", tag, dut.ptr_q, mPtr);
    end
  endtask

  // Drive one clock worth of inputs, then compare just after the edge.
  task automatic applyStimulus(input bit r, input bit c, input bit rh,
                               input logic [2:0] rq, input bit ld,
                               input logic [22:0] sd, input string tag);
    rst   = r;
    cen   = c;
    rhyEn = rh;
    req   = rq;
    load  = ld;
    seed  = sd;
    @(posedge clk);
    modelClock();
    #1;
    checkOutput(tag);
  endtask

  task automatic checkConst(input string tag, input logic [22:0] got,
                            input logic [22:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    logic [2:0] pending;
    logic [2:0] contention [4];
    contention[0] = 3'b001;
    contention[1] = 3'b010;
    contention[2] = 3'b100;
    contention[3] = 3'b000;
    rst = 1'b1; cen = 1'b0; rhyEn = 1'b0; req = 3'b000; load = 1'b0; seed = '0;
    modelReset();

    applyStimulus(1, 0, 0, 3'b000, 0, '0, "reset");
    applyStimulus(1, 1, 0, 3'b000, 0, '0, "reset");

    // Free-running LFSR from reset
    for (int i = 1; i <= 400; i++) begin
      applyStimulus(0, 1, 0, 3'b000, 0, '0, "steps");
      if (i == 18) checkConst("lfsr_after_18", dut.lfsr_w, 23'h200000);
      if (i == 395) checkConst("snap_before_396", 23'(dut.snap_q), 23'd0);
      if (i == 396) checkConst("snap_at_396", 23'(dut.snap_q), 23'd1);
    end

    // Full contention from a fresh sample
    applyStimulus(1, 1, 0, 3'b000, 0, '0, "reset");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, 1, 1, 3'b111, 0, '0, "contention");
      if (i < 4) checkConst("contention_seq", 23'(gnt), 23'(contention[i]));
    end

    // Rhythm disabled holds requests off
    for (int i = 0; i < 50; i++) begin
      applyStimulus(0, 1, 0, 3'b101, 0, '0, "rhy_off");
      if (i == 49) checkConst("rhy_off_gnt", 23'(gnt), 23'd0);
    end
    applyStimulus(0, 1, 1, 3'b101, 0, '0, "rhy_on");
    checkConst("rhy_on_first", 23'(gnt), 23'b001);
    applyStimulus(0, 1, 1, 3'b100, 0, '0, "rhy_on");
    checkConst("rhy_on_second", 23'(gnt), 23'b100);

    // Let the noise bit become interesting, then collide with the wrap
    for (int i = 0; i < 420; i++) applyStimulus(0, 1, 0, 3'b000, 0, '0, "run");
    while (mSlot != 17) applyStimulus(0, 1, 1, 3'b000, 0, '0, "align");
    applyStimulus(0, 1, 1, 3'b010, 0, '0, "collision");
    checkConst("collision_gnt", 23'(gnt), 23'b010);
    checkConst("collision_slot", 23'(slot), 23'd0);

    // Randomized traffic with requesters following the hold-until-granted rule
    pending = 3'b000;
    for (int i = 0; i < 1500; i++) begin
      pending = pending & ~gnt;
      pending = pending | (3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7)));
      applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 4) != 0), pending, 0, '0, "random");
      if (rst) pending = 3'b000;
    end

    // Reset in the middle of a sample with a grant outstanding
    applyStimulus(1, 1, 0, 3'b000, 0, '0, "reset");
    applyStimulus(0, 1, 1, 3'b001, 0, '0, "pre_mid");
    while (mSlot != 9) applyStimulus(0, 1, 1, 3'b000, 0, '0, "to_slot9");
    applyStimulus(0, 1, 1, 3'b010, 0, '0, "slot9_grant");
    applyStimulus(1, 1, 1, 3'b010, 0, '0, "mid_reset");
    checkConst("mid_reset_slot", 23'(slot), 23'd0);
    checkConst("mid_reset_gnt", 23'(gnt), 23'd0);
    checkConst("mid_reset_lfsr", dut.lfsr_w, 23'h400000);
    checkConst("mid_reset_ptr", 23'(dut.ptr_q), 23'd0);
    checkConst("mid_reset_smp", 23'(smp), 23'd1);

`ifdef JTOPL_NOISE_LOAD_EN
    // Zero seed recovers on the following step
    applyStimulus(0, 1, 0, 3'b000, 1, 23'd0, "load_zero");
    checkConst("load_zero_lfsr", dut.lfsr_w, 23'd0);
    while (mSlot != 0) applyStimulus(0, 1, 0, 3'b000, 0, '0, "to_boundary");
    checkConst("zero_lock", dut.lfsr_w, 23'h400000);
    for (int i = 0; i < 200; i++)
      applyStimulus(0, 1, 1, 3'($urandom_range(0, 7)), ($urandom_range(0, 19) == 0),
                    23'($urandom), "load_random");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtopl_noise_ctl.md
# jtopl_noise_ctl

Scheduler for the OPL rhythm noise source. Runs a per-sample slot counter and advances the 23-bit noise LFSR exactly once per sample. Freezes a per-sample snapshot of the noise bit. Shares that bit among the three noise-consuming rhythm voices (hi-hat, snare, top-cymbal) through a round-robin request/grant handshake. Sits between the operator slot sequencer and the rhythm phase-generation logic.

## Interface
- `SLOTS`, 18: slots per sample; LFSR steps when the counter wraps from `SLOTS-1` to 0.
- `rst`  in  1  synchronous, active-high reset.
- `clk`  in  1  system clock; the only clock.
- `cen`  in  1  clock enable; all state advances only when `cen`=1.
- `rhy_en`  in  1  rhythm mode enable; grants are issued only when this is 1.
- `req`  in  3  requests; bit0 = HH, bit1 = SD, bit2 = TC; each held high until granted.
- `load`  in  1  seed load strobe; active only with `JTOPL_NOISE_LOAD_EN`.
- `seed`  in  23  seed value; active only with `JTOPL_NOISE_LOAD_EN`.
- `gnt`  out  3  one-hot grant, high for one `cen` cycle.
- `nbit`  out  1  snapshot noise bit; valid whenever any `gnt` bit is 1.
- `slot`  out  5  current slot index, 0..`SLOTS-1`.
- `smp`  out  1  high for the single `cen` cycle in which `slot`==0.

## Operation
- **Reset values:**
  - `lfsr` = 23'h400000, `snap` = 0, `slot` = 0, `smp` = 1.
  - `gnt` = 0, `nbit` = 0.
  - Round-robin pointer `ptr` = 0, served mask `srv` = 3'b000.
- **Slot counter:** increments on each `cen`. It wraps from `SLOTS-1` to 0; that wrap cycle is the *boundary*.
- **LFSR step (boundary only):**
  - fb = `lfsr[0]` ^ `lfsr[14]`, forced to 1 when `lfsr`==0.
  - `lfsr` <= {fb, `lfsr[22:1]`}.
- **Snapshot:** on the boundary, `snap` <= the post-step `lfsr[0]`. It is computed combinationally from the pre-step value, so it is visible in the same cycle the step registers. Every grant within one sample therefore returns the same bit.
- **Served mask:** `srv` clears on the boundary. The granted requester's `srv` bit sets at grant time. Eligible = `req` & ~`srv`.
- **Arbitration:** evaluated on each `cen` cycle.
  - If `rhy_en`=1 and eligible≠0, grant the first eligible index searching from `ptr` upward, with wrap.
  - On a grant, `ptr` <= granted index + 1 (mod 3).
  - `nbit` <= `snap`, or the new snapshot value on a boundary cycle.
- **No grant:** `gnt` <= 0 and `nbit` holds. This applies when `rhy_en`=0 or nothing is eligible. Pending requests stay pending and `srv` is not modified.
- **Boundary plus grant in the same cycle:** `srv` is cleared first, then the grant bit is set. The grant carries the new sample's snapshot.
- **Request protocol:** a requester drops `req` in the cycle after seeing its `gnt`. If `req` is still high while `srv` is set, it is not granted again in the same sample.
- **LFSR zero state:** an all-zero `lfsr` recovers to 23'h400000 on the next step.

## Timing
- Grant latency: `req` seen high at `cen` cycle N produces `gnt` registered at cycle N, visible from N+1. Worst case is 3 `cen` cycles when all three requesters compete.
- Throughput: at most one grant per `cen` cycle and at most 3 grants per sample.
- Outputs are registered, with no combinational path from inputs to outputs.
- Synchronous reset overrides `cen` and restores all reset values in one `clk` edge, including mid-sample. Slot numbering restarts at 0 with `smp`=1.

## Configuration
- `JTOPL_NOISE_LOAD_EN` defined:
  - `load`=1 with `cen`=1 sets `lfsr` <= `seed` and takes priority over a simultaneous boundary step.
  - `snap`, `slot`, `srv` and `ptr` are unaffected; the loaded value reaches `snap` at the next boundary.
- Undefined: `load` and `seed` are ignored, with no logic generated for them. The ports stay present for a stable instance interface.

## Structure
- **Shared package `jtopl_pkg`:**
  - LFSR width 23.
  - Reset seed 23'h400000.
  - Feedback tap index 14.
  - Requester indices HH=0, SD=1, TC=2.
- **Sub-module `jtopl_noise_lfsr`:** the 23-bit register with step and optional load, and the zero-lock guard. It exposes the next-state bit0 for the snapshot.
- **Top level:** slot counter, served mask, round-robin arbiter, output registers.

## Test plan
- **Reset then steps:** reset, then `cen`=1 continuously.
  - At 18 cycles `lfsr`=23'h200000 and `smp` pulses every 18 cycles.
  - `snap` stays 0 until the 22nd boundary (cycle 396), where it becomes 1.
- **Full contention:** `rhy_en`=1, `req`=3'b111 held.
  - `gnt` = 001, 010, 100 on three consecutive `cen` cycles, then 000 until the boundary, then the sequence repeats.
  - Every `nbit` in a sample equals `snap`.
- **Rhythm disabled:** `rhy_en`=0 with `req`=3'b101 → `gnt` stays 0 for 50 cycles. Setting `rhy_en`=1 → `gnt`=001 on the next cycle, then 100.
- **Boundary collision:** `req`=3'b010 first asserted on the wrap cycle → grant in that cycle, and `nbit` equals the new sample's snapshot.
- **Zero lock (`JTOPL_NOISE_LOAD_EN` defined):** `load`=1 with `seed`=0 → the next boundary gives `lfsr`=23'h400000.
- **Reset mid-sample:** `rst` at slot 9 with `gnt`=010 pending → next cycle shows `slot`=0, `gnt`=0, `lfsr`=23'h400000, `ptr`=0.
